// File: rtl/flash_word_responder.sv
// flash_word_responder: serves 32-bit word reads by fetching four bytes from a byte-wide flash,
// substituting 8'hFF for any byte that does not arrive within TIMEOUT wait cycles.
module flash_word_responder #(
  parameter int TIMEOUT       = 255,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        read,
  input  logic [22:0] address,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        readerror,
  output logic [24:0] byte_addr,
  output logic        byte_rd,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BYTE, RESPOND} state_t;
  state_t      state;
  logic [22:0] addr_q;
  logic [1:0]  idx;
  logic [CW-1:0] cnt;
  logic        err;
  logic [31:0] word;
  logic        timed_out;
  logic        advance;
  logic [1:0]  lane;
  logic [31:0] word_next;
  always_comb begin
    timed_out = !byte_valid && cnt == CW'(TIMEOUT - 1);
    advance   = byte_valid || timed_out;
    lane      = LITTLE_ENDIAN ? idx : 2'd3 - idx;
    word_next = word;
    word_next[{lane, 3'b000} +: 8] = byte_valid ? byte_data : 8'hFF;
  end
  // Outputs are registered on the transition into the state that owns them.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state         <= IDLE;
      addr_q        <= '0;
      idx           <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      word          <= '0;
      waitrequest   <= 1'b0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      readerror     <= 1'b0;
      byte_addr     <= '0;
      byte_rd       <= 1'b0;
    end else begin
      byte_rd       <= 1'b0;
      readdatavalid <= 1'b0;
      readerror     <= 1'b0;
      case (state)
        IDLE: if (read) begin
          addr_q      <= address;
          idx         <= 2'd0;
          err         <= 1'b0;
          waitrequest <= 1'b1;
          byte_addr   <= {address, 2'd0};
          byte_rd     <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BYTE;
        end
        WAIT_BYTE: if (advance) begin
          word <= word_next;
          err  <= err | timed_out;
          if (idx == 2'd3) begin
            readdata      <= word_next;
            readdatavalid <= 1'b1;
            readerror     <= err | timed_out;
            state         <= RESPOND;
          end else begin
            idx       <= idx + 2'd1;
            byte_addr <= {addr_q, idx + 2'd1};
            byte_rd   <= 1'b1;
            state     <= ISSUE;
          end
        end else cnt <= cnt + 1'b1;
        RESPOND: begin
          waitrequest <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_word_responder.sv
// tb_flash_word_responder: timeline-driven bench; a transaction-level model predicts every output cycle
// for a little-endian and a big-endian instance sharing the same stimulus.
module tb_flash_word_responder;
  localparam int TO = 4;
  localparam int N  = 400;
  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;
  logic        reset, read, byte_valid;
  logic [22:0] address;
  logic [7:0]  byte_data;
  logic        wr_a, rdv_a, err_a, brd_a, wr_b, rdv_b, err_b, brd_b;
  logic [31:0] rd_a, rd_b;
  logic [24:0] ba_a, ba_b;
  flash_word_responder #(.TIMEOUT(TO), .LITTLE_ENDIAN(1'b1)) dut_a (
    .clk_50(clk_50), .reset(reset), .read(read), .address(address), .waitrequest(wr_a),
    .readdata(rd_a), .readdatavalid(rdv_a), .readerror(err_a), .byte_addr(ba_a), .byte_rd(brd_a),
    .byte_data(byte_data), .byte_valid(byte_valid));
  flash_word_responder #(.TIMEOUT(TO), .LITTLE_ENDIAN(1'b0)) dut_b (
    .clk_50(clk_50), .reset(reset), .read(read), .address(address), .waitrequest(wr_b),
    .readdata(rd_b), .readdatavalid(rdv_b), .readerror(err_b), .byte_addr(ba_b), .byte_rd(brd_b),
    .byte_data(byte_data), .byte_valid(byte_valid));
  logic        s_rst[N], s_read[N], s_val[N];
  logic [22:0] s_addr[N];
  logic [7:0]  s_dat[N];
  logic        e_chk[N], e_wr[N], e_brd[N], e_rdv[N], e_err[N];
  logic [24:0] e_ba[N];
  logic [31:0] e_da[N], e_db[N];
  logic [24:0] m_addr;
  logic [31:0] m_da, m_db;
  int n_tests = 0;
  int n_fail  = 0;
  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, k, act, exp);
    end
  endtask
  task automatic setx(input int c, input logic wr, input logic brd, input logic rdv, input logic er);
    e_chk[c] = 1'b1;
    e_wr[c]  = wr;
    e_brd[c] = brd;
    e_rdv[c] = rdv;
    e_err[c] = er;
    e_ba[c]  = m_addr;
    e_da[c]  = m_da;
    e_db[c]  = m_db;
  endtask
  task automatic idle_from(input int k);
    for (int c = k; c < N; c++) setx(c, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset(input int k);
    s_rst[k] = 1'b1;
    m_addr = '0;
    m_da = '0;
    m_db = '0;
    for (int c = k + 1; c < N; c++) s_val[c] = 1'b0;
    idle_from(k + 1);
  endtask
  // b: byte i at b[8i+:8]; dl: wait cycles before byte i at dl[8i+:8], >= TO means it never arrives.
  task automatic txn(input int t, input logic [22:0] a, input logic [31:0] b, input logic [31:0] dl, output int r);
    int c, w, dd;
    logic e;
    logic [7:0] v;
    logic [31:0] wa, wb;
    s_addr[t] = a;
    c = t + 1;
    e = 1'b0;
    wa = '0;
    wb = '0;
    for (int i = 0; i < 4; i++) begin
      dd = int'(dl[8*i +: 8]);
      w = dd < TO ? dd + 1 : TO;
      v = dd < TO ? b[8*i +: 8] : 8'hFF;
      e = e | (dd >= TO);
      if (dd < TO) begin
        s_val[c + 1 + dd] = 1'b1;
        s_dat[c + 1 + dd] = b[8*i +: 8];
      end
      m_addr = {a, 2'(i)};
      for (int j = 0; j <= w; j++) setx(c + j, 1'b1, j == 0, 1'b0, 1'b0);
      wa[8*i +: 8] = v;
      wb[24 - 8*i +: 8] = v;
      c = c + 1 + w;
    end
    m_da = wa;
    m_db = wb;
    setx(c, 1'b1, 1'b0, 1'b1, e);
    idle_from(c + 1);
    r = c;
  endtask
  task automatic drive(input int k);
    reset      = s_rst[k];
    read       = s_read[k];
    address    = s_addr[k];
    byte_valid = s_val[k];
    byte_data  = s_dat[k];
  endtask
  initial begin
    int t, r, r1, t2, last;
    for (int c = 0; c < N; c++) begin
      s_rst[c] = 0; s_read[c] = 0; s_val[c] = 0; s_addr[c] = '0; s_dat[c] = '0;
      e_chk[c] = 0; e_wr[c] = 0; e_brd[c] = 0; e_rdv[c] = 0; e_err[c] = 0;
      e_ba[c] = '0; e_da[c] = '0; e_db[c] = '0;
    end
    do_reset(0); do_reset(1); do_reset(2);
    // zero-wait read of word 0x10
    t = 4;
    s_read[t] = 1;
    txn(t, 23'h000010, 32'h44332211, 32'h0, r);
    chk("model_latency", r, r - t, 9);
    chk("model_word_le", r, e_da[r], 32'h44332211);
    chk("model_word_be", r, e_db[r], 32'h11223344);
    chk("model_addr0", t + 1, e_ba[t + 1], 25'h40);
    // byte 2 never arrives
    t = r + 2;
    s_read[t] = 1;
    txn(t, 23'h123456, 32'hD4C3B2A1, {8'd1, 8'd99, 8'd2, 8'd0}, r);
    chk("model_to_latency", r, r - t, 15);
    chk("model_to_word", r, e_da[r], 32'hD4FFB2A1);
    chk("model_to_err", r, e_err[r], 1);
    // bytes arriving on the very cycle the counter expires
    t = r + 3;
    s_read[t] = 1;
    txn(t, 23'h2AAAAA, 32'h5A6B7C8D, {8'd3, 8'd0, 8'd3, 8'd0}, r);
    chk("model_race_err", r, e_err[r], 0);
    chk("model_race_be", r, e_db[r], 32'h8D7C6B5A);
    // stray byte_valid in IDLE, then read held high for 30 cycles
    t = r + 3;
    s_val[t - 1] = 1;
    s_dat[t - 1] = 8'hEE;
    for (int c = t; c < t + 30; c++) s_read[c] = 1;
    txn(t, 23'h000100, 32'h0D0C0B0A, {8'd1, 8'd1, 8'd1, 8'd1}, r1);
    txn(r1 + 1, 23'h000200, 32'h1D1C1B1A, {8'd2, 8'd2, 8'd2, 8'd2}, r);
    chk("model_b2b_first", r1, r1 - t, 13);
    chk("model_b2b_second", r, r - t, 31);
    // reset during the wait for byte 1, read asserted alongside reset
    t = r + 3;
    s_read[t] = 1;
    txn(t, 23'h0ABCDE, 32'h04030201, {8'd0, 8'd0, 8'd99, 8'd0}, r);
    do_reset(t + 5);
    s_read[t + 5] = 1;
    chk("model_rst_data", t + 6, e_da[t + 6], 32'h0);
    t2 = t + 8;
    s_read[t2] = 1;
    txn(t2, 23'h7FFFFF, 32'hDDCCBBAA, {8'd0, 8'd0, 8'd1, 8'd0}, r);
    chk("model_wrap_lo", t2 + 1, e_ba[t2 + 1], 25'h1FFFFFC);
    chk("model_wrap_hi", r, e_ba[r], 25'h1FFFFFF);
    // every byte times out
    t = r + 2;
    s_read[t] = 1;
    txn(t, 23'h000001, 32'h0, {8'd99, 8'd99, 8'd99, 8'd99}, r);
    chk("model_allto_latency", r, r - t, 21);
    chk("model_allto_word", r, e_da[r], 32'hFFFFFFFF);
    last = r + 5;
    drive(0);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk_50);
      if (e_chk[k]) begin
        chk("waitrequest_a", k, wr_a, e_wr[k]);
        chk("waitrequest_b", k, wr_b, e_wr[k]);
        chk("byte_rd_a", k, brd_a, e_brd[k]);
        chk("byte_rd_b", k, brd_b, e_brd[k]);
        chk("byte_addr_a", k, ba_a, e_ba[k]);
        chk("byte_addr_b", k, ba_b, e_ba[k]);
        chk("readdatavalid_a", k, rdv_a, e_rdv[k]);
        chk("readdatavalid_b", k, rdv_b, e_rdv[k]);
        chk("readerror_a", k, err_a, e_err[k]);
        chk("readerror_b", k, err_b, e_err[k]);
        chk("readdata_le", k, rd_a, e_da[k]);
        chk("readdata_be", k, rd_b, e_db[k]);
      end
      drive(k);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
